// File: rtl/led_status_arbiter.sv
// Fixed-priority arbiter sharing one LED bank between status requesters, with minimum hold and off-gap.
// Optional build macro LED_HEARTBEAT_EN: slow heartbeat on o_led[0] while idle.
module led_status_arbiter #(
  parameter int LED_NUM    = 8,
  parameter int REQ_NUM    = 4,
  parameter int STS_FREQ   = 125_000_000,
  parameter int TICK_DIV   = STS_FREQ / 8,
  parameter int HOLD_TICKS = 16
) (
  input  logic                       i_Sys_clk,
  input  logic                       i_Rst_n,
  input  logic [REQ_NUM-1:0]         i_req,
  input  logic [REQ_NUM*LED_NUM-1:0] i_pattern,
  input  logic [REQ_NUM-1:0]         i_blink,
  output logic [REQ_NUM-1:0]         o_grant,
  output logic                       o_busy,
  output logic [LED_NUM-1:0]         o_led
);

  localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam int IDX_W  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHOW = 2'd1, ST_GAP = 2'd2} state_t;

  state_t              state_r, state_nxt_s;
  logic [CNT_W-1:0]    tick_cnt_r;
  logic                tick_s;
  logic [LED_NUM-1:0]  pat_r, pat_nxt_s, sel_pat_s, led_nxt_s;
  logic                blink_r, blink_nxt_s, sel_blink_s;
  logic                phase_r, phase_nxt_s, busy_nxt_s;
  logic [HOLD_W-1:0]   hold_cnt_r, hold_nxt_s;
  logic [REQ_NUM-1:0]  grant_nxt_s, win_oh_s;
  logic [IDX_W-1:0]    win_idx_s;
  logic                owner_req_s, hp_req_s, hold_done_s, enter_s;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [REQ_NUM-1:0] req);
    lowest_idx = {IDX_W{1'b0}};
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      if (req[k]) lowest_idx = IDX_W'(k);
      else        lowest_idx = lowest_idx;
    end
  endfunction

  assign tick_s      = (tick_cnt_r == CNT_MAX);
  assign win_idx_s   = lowest_idx(i_req);
  assign win_oh_s    = REQ_NUM'(1'b1) << win_idx_s;
  assign sel_pat_s   = i_pattern[win_idx_s*LED_NUM +: LED_NUM];
  assign sel_blink_s = i_blink[win_idx_s];
  // o_grant is one-hot in SHOW, so grant-1 masks exactly the higher-priority requesters
  assign owner_req_s = |(i_req & o_grant);
  assign hp_req_s    = |(i_req & (o_grant - REQ_NUM'(1'b1)));
  assign hold_done_s = (hold_cnt_r == HOLD_MAX);
  assign enter_s     = (state_r == ST_IDLE) && (state_nxt_s == ST_SHOW);

  // Free-running tick prescaler
  always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
    if (!i_Rst_n)    tick_cnt_r <= {CNT_W{1'b0}};
    else if (tick_s) tick_cnt_r <= {CNT_W{1'b0}};
    else             tick_cnt_r <= tick_cnt_r + CNT_W'(1);
  end

  // State register
  always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (|i_req) state_nxt_s = ST_SHOW;
        else        state_nxt_s = ST_IDLE;
      end
      ST_SHOW: begin
        if (hold_done_s && (!owner_req_s || hp_req_s)) state_nxt_s = ST_GAP;
        else                                           state_nxt_s = ST_SHOW;
      end
      ST_GAP: begin
        if (tick_s) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_GAP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

`ifdef LED_HEARTBEAT_EN
  logic [2:0] hb_cnt_r, hb_cnt_nxt_s;
  logic       hb_phase_r, hb_phase_nxt_s;

  // Heartbeat advances only while idling; cleared whenever a grant starts
  always_comb begin
    hb_cnt_nxt_s   = hb_cnt_r;
    hb_phase_nxt_s = hb_phase_r;
    if (enter_s) begin
      hb_cnt_nxt_s   = 3'd0;
      hb_phase_nxt_s = 1'b0;
    end else if ((state_r == ST_IDLE) && tick_s) begin
      hb_cnt_nxt_s   = hb_cnt_r + 3'd1;
      hb_phase_nxt_s = (hb_cnt_r == 3'd7) ? ~hb_phase_r : hb_phase_r;
    end else begin
      hb_cnt_nxt_s   = hb_cnt_r;
      hb_phase_nxt_s = hb_phase_r;
    end
  end

  // Heartbeat registers
  always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hb_cnt_r   <= 3'd0;
      hb_phase_r <= 1'b0;
    end else begin
      hb_cnt_r   <= hb_cnt_nxt_s;
      hb_phase_r <= hb_phase_nxt_s;
    end
  end
`endif

  // Output and grant-context next values, registered below so all outputs are flops
  always_comb begin
    pat_nxt_s   = pat_r;
    blink_nxt_s = blink_r;
    hold_nxt_s  = hold_cnt_r;
    phase_nxt_s = phase_r;
    grant_nxt_s = {REQ_NUM{1'b0}};
    led_nxt_s   = {LED_NUM{1'b0}};
    busy_nxt_s  = (state_nxt_s != ST_IDLE);
    if (enter_s) begin
      pat_nxt_s   = sel_pat_s;
      blink_nxt_s = sel_blink_s;
      hold_nxt_s  = {HOLD_W{1'b0}};
      phase_nxt_s = 1'b1;
      grant_nxt_s = win_oh_s;
      led_nxt_s   = sel_pat_s;
    end else if ((state_r == ST_SHOW) && (state_nxt_s == ST_SHOW)) begin
      if (tick_s) begin
        hold_nxt_s  = hold_done_s ? hold_cnt_r : hold_cnt_r + HOLD_W'(1);
        phase_nxt_s = blink_r ? ~phase_r : phase_r;
      end else begin
        hold_nxt_s  = hold_cnt_r;
        phase_nxt_s = phase_r;
      end
      grant_nxt_s = o_grant;
      led_nxt_s   = phase_nxt_s ? pat_r : {LED_NUM{1'b0}};
    end else begin
      hold_nxt_s  = {HOLD_W{1'b0}};
      phase_nxt_s = 1'b0;
`ifdef LED_HEARTBEAT_EN
      if (state_nxt_s == ST_IDLE) led_nxt_s = LED_NUM'(hb_phase_nxt_s);
      else                        led_nxt_s = {LED_NUM{1'b0}};
`else
      led_nxt_s   = {LED_NUM{1'b0}};
`endif
    end
  end

  // Grant context and output registers
  always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      pat_r      <= {LED_NUM{1'b0}};
      blink_r    <= 1'b0;
      hold_cnt_r <= {HOLD_W{1'b0}};
      phase_r    <= 1'b0;
      o_grant    <= {REQ_NUM{1'b0}};
      o_busy     <= 1'b0;
      o_led      <= {LED_NUM{1'b0}};
    end else begin
      pat_r      <= pat_nxt_s;
      blink_r    <= blink_nxt_s;
      hold_cnt_r <= hold_nxt_s;
      phase_r    <= phase_nxt_s;
      o_grant    <= grant_nxt_s;
      o_busy     <= busy_nxt_s;
      o_led      <= led_nxt_s;
    end
  end

endmodule

// File: tb/tb_led_status_arbiter.sv
// Bench for led_status_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic against a behavioural model (TICK_DIV=4, HOLD_TICKS=2).
module tb_led_status_arbiter;
  localparam int LED_NUM    = 8;
  localparam int REQ_NUM    = 4;
  localparam int TICK_DIV   = 4;
  localparam int HOLD_TICKS = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'd0;
  logic [31:0] pattern = 32'd0;
  logic [3:0]  blink = 4'd0;
  logic [3:0]  grant;
  logic        busy;
  logic [7:0]  led;
  int checks = 0;
  int failures = 0;

  led_status_arbiter #(
    .LED_NUM(LED_NUM), .REQ_NUM(REQ_NUM), .STS_FREQ(32),
    .TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .i_Sys_clk(clk), .i_Rst_n(rst_n), .i_req(req), .i_pattern(pattern),
    .i_blink(blink), .o_grant(grant), .o_busy(busy), .o_led(led)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 idle, 1 showing, 2 gap; cycle count since reset gives the tick
  int         m_mode, m_owner, m_held, m_cyc;
  logic [7:0] m_pat;
  bit         m_blink, m_lit;

  function automatic void m_reset();
    m_mode = 0; m_owner = 0; m_held = 0; m_cyc = 0;
    m_pat = 8'd0; m_blink = 1'b0; m_lit = 1'b0;
  endfunction

  function automatic void m_step();
    bit t;
    int w;
    t = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
    w = -1;
    case (m_mode)
      0: begin
        for (int k = REQ_NUM - 1; k >= 0; k--) if (req[k]) w = k;
        if (w >= 0) begin
          m_owner = w; m_pat = pattern[w*LED_NUM +: LED_NUM]; m_blink = blink[w];
          m_held = 0; m_lit = 1'b1; m_mode = 1;
        end
      end
      1: begin
        if (m_held >= HOLD_TICKS && (!req[m_owner] || (req & ((4'd1 << m_owner) - 4'd1)) != 4'd0))
          m_mode = 2;
        else if (t) begin
          if (m_held < HOLD_TICKS) m_held++;
          if (m_blink) m_lit = !m_lit;
        end
      end
      2: if (t) m_mode = 0;
      default: m_mode = 0;
    endcase
    m_cyc++;
  endfunction

  function automatic logic [12:0] m_exp();
    logic [3:0] g;
    logic [7:0] l;
    g = (m_mode == 1) ? (4'd1 << m_owner) : 4'd0;
    l = (m_mode == 1 && m_lit) ? m_pat : 8'd0;
    return {g, (m_mode != 0), l};
  endfunction

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got grant=%b busy=%b led=%h, expected grant=%b busy=%b led=%h",
               name, act[12:9], act[8], act[7:0], exp[12:9], exp[8], exp[7:0]);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 4'd0; pattern = 32'd0; blink = 4'd0;
    #3;
    chk("reset", {grant, busy, led}, 13'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] pat;
    logic [3:0]  blink;
    int          n;
    logic [3:0]  grant;
    logic        busy;
    logic [7:0]  led;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [7:0]  exp_led;
    logic [12:0] exp;

    // Expected outputs after each clock, ticks fall in cycles 3, 7, 11, ...
    vecs.push_back('{4'b0100, 32'h00A50000, 4'b0000, 1, 4'b0100, 1'b1, 8'hA5});
    vecs.push_back('{4'b0000, 32'h00A50000, 4'b0000, 7, 4'b0100, 1'b1, 8'hA5});
    vecs.push_back('{4'b0000, 32'h00A50000, 4'b0000, 3, 4'b0000, 1'b1, 8'h00});
    vecs.push_back('{4'b0000, 32'h00A50000, 4'b0000, 1, 4'b0000, 1'b0, 8'h00});
    vecs.push_back('{4'b1011, 32'h1122333C, 4'b0000, 1, 4'b0001, 1'b1, 8'h3C});
    vecs.push_back('{4'b1010, 32'h112233C3, 4'b0000, 7, 4'b0001, 1'b1, 8'h3C});
    vecs.push_back('{4'b1010, 32'h112233C3, 4'b0000, 3, 4'b0000, 1'b1, 8'h00});
    vecs.push_back('{4'b1010, 32'h112233C3, 4'b0000, 1, 4'b0000, 1'b0, 8'h00});
    vecs.push_back('{4'b1010, 32'h112233C3, 4'b0000, 1, 4'b0010, 1'b1, 8'h33});

    do_reset();
    for (int i = 0; i < 100; i++) begin
      clk_step();
      chk("idle", {grant, busy, led}, 13'd0);
    end

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      req = vecs[i].req; pattern = vecs[i].pat; blink = vecs[i].blink;
      for (int j = 0; j < vecs[i].n; j++) begin
        clk_step();
        chk($sformatf("vec%0d_%0d", i, j), {grant, busy, led},
            {vecs[i].grant, vecs[i].busy, vecs[i].led});
      end
    end

    // Blinking owner: first toggle at the tick in cycle 3, then every 4 clocks
    do_reset();
    req = 4'b0010; pattern = 32'h0000FF00; blink = 4'b0010;
    for (int k = 1; k <= 40; k++) begin
      clk_step();
      exp_led = (((k / 4) % 2) == 0) ? 8'hFF : 8'h00;
      chk($sformatf("blink_%0d", k), {grant, busy, led}, {4'b0010, 1'b1, exp_led});
    end

    // Higher priority arrives during hold: no preemption until hold met
    do_reset();
    req = 4'b1000; pattern = 32'h5A000077;
    clk_step();
    chk("hold_1", {grant, busy, led}, {4'b1000, 1'b1, 8'h5A});
    req = 4'b1001;
    for (int k = 2; k <= 13; k++) begin
      clk_step();
      if (k <= 8)       exp = {4'b1000, 1'b1, 8'h5A};
      else if (k <= 11) exp = {4'b0000, 1'b1, 8'h00};
      else if (k == 12) exp = {4'b0000, 1'b0, 8'h00};
      else              exp = {4'b0001, 1'b1, 8'h77};
      chk($sformatf("hold_%0d", k), {grant, busy, led}, exp);
    end

    // Asynchronous reset in the middle of SHOW
    do_reset();
    req = 4'b0001; pattern = 32'h000000C6;
    clk_step();
    clk_step();
    chk("pre_rst", {grant, busy, led}, {4'b0001, 1'b1, 8'hC6});
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {grant, busy, led}, 13'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    #1 chk("post_release", {grant, busy, led}, 13'd0);
    clk_step();
    chk("regrant", {grant, busy, led}, {4'b0001, 1'b1, 8'hC6});

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0)
        req = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) pattern = $urandom();
      if ($urandom_range(0, 15) == 0) blink = 4'($urandom_range(0, 15));
      clk_step();
      chk("rand", {grant, busy, led}, m_exp());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
